// File: rtl/wb_pkg.sv
// Shared Wishbone B3 cycle-type and burst-type encodings plus the burst master FSM states.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_RETRY,
    ST_END
  } wbm_state_t;

endpackage

// File: rtl/wb_adr_next.sv
// Next word address of a Wishbone burst: linear increment or modulo increment
// inside a 4/8/16-word wrap window, leaving the bits above the window untouched.
module wb_adr_next
  import wb_pkg::*;
#(
  parameter int unsigned AW = 32
) (
  input  logic [AW-1:0] adr,
  input  logic [1:0]    bte,
  output logic [AW-1:0] adr_next
);

  logic [AW-1:0] inc;
  logic [AW-1:0] mask;

  // Bits under the mask come from the incremented address, the rest from the current one.
  always_comb begin
    inc  = adr + AW'(4);
    mask = '0;
    case (bte)
      BTE_WRAP4:  mask[3:2] = '1;
      BTE_WRAP8:  mask[4:2] = '1;
      BTE_WRAP16: mask[5:2] = '1;
      default:    mask      = '1;
    endcase
    adr_next = (adr & ~mask) | (inc & mask);
  end

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B3 initiator turning block read/write commands into classic or
// incrementing/wrapping bursts, with err abort and bounded rty reissue.
module wb_burst_master
  import wb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned RTY_MAX = 4
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [AW-1:0]   cmd_adr_i,
  input  logic [4:0]      cmd_len_i,
  input  logic [1:0]      cmd_bte_i,
  input  logic [DW-1:0]   wr_dat_i,
  input  logic            wr_valid_i,
  output logic            wr_ready_o,
  output logic [DW-1:0]   rd_dat_o,
  output logic            rd_valid_o,
  output logic            done_o,
  output logic            err_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_we_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic [2:0]      wb_cti_o,
  output logic [1:0]      wb_bte_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  input  logic            wb_rty_i
);

  localparam int unsigned RW = $clog2(RTY_MAX + 1);

  wbm_state_t    state, state_nxt;
  logic [AW-1:0] adr;
  logic [AW-1:0] adr_inc;
  logic [4:0]    beats;
  logic          burst;
  logic          we;
  logic [1:0]    bte;
  logic          hold_full;
  logic [DW-1:0] hold_dat;
  logic [RW-1:0] rty_cnt;
  logic          end_err;
  logic [DW-1:0] rd_dat;
  logic          rd_valid;

  logic cmd_fire;
  logic wr_fire;
  logic stb;
  logic last_beat;
  logic ack_take;
  logic rty_take;
  logic err_take;
  logic rty_abort;

  wb_adr_next #(.AW(AW)) u_adr_next (
    .adr      (adr),
    .bte      (bte),
    .adr_next (adr_inc)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    stb         = (state == ST_BUS) && (!we || hold_full);
    last_beat   = (beats == 5'd1);
    // err outranks rty, which outranks ack; nothing counts without stb.
    err_take    = stb && wb_err_i;
    rty_take    = stb && wb_rty_i && !wb_err_i;
    ack_take    = stb && wb_ack_i && !wb_err_i && !wb_rty_i;
    rty_abort   = (rty_cnt == RW'(RTY_MAX - 1));
    cmd_ready_o = (state == ST_IDLE) && !wb_rst_i;
    cmd_fire    = cmd_valid_i && cmd_ready_o;
    wr_ready_o  = we && (state == ST_BUS) && (!hold_full || (ack_take && !last_beat));
    wr_fire     = wr_valid_i && wr_ready_o;

    case (state)
      ST_IDLE: if (cmd_fire) state_nxt = ST_BUS;
      ST_BUS: begin
        if (err_take || (rty_take && rty_abort) || (ack_take && last_beat))
          state_nxt = ST_END;
        else if (rty_take)
          state_nxt = ST_RETRY;
      end
      ST_RETRY: state_nxt = ST_BUS;
      ST_END:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase

    wb_cyc_o = (state == ST_BUS);
    wb_stb_o = stb;
    wb_we_o  = wb_cyc_o && we;
    wb_sel_o = {(DW/8){wb_cyc_o}};
    wb_adr_o = adr;
    wb_dat_o = hold_dat;
    if (!wb_cyc_o || !burst) wb_cti_o = CTI_CLASSIC;
    else if (last_beat)      wb_cti_o = CTI_EOB;
    else                     wb_cti_o = CTI_INC;
    wb_bte_o   = (wb_cyc_o && burst) ? bte : BTE_LINEAR;
    done_o     = (state == ST_END) && !end_err;
    err_o      = (state == ST_END) && end_err;
    rd_dat_o   = rd_dat;
    rd_valid_o = rd_valid;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      adr       <= '0;
      beats     <= '0;
      burst     <= 1'b0;
      we        <= 1'b0;
      bte       <= BTE_LINEAR;
      hold_full <= 1'b0;
      hold_dat  <= '0;
      rty_cnt   <= '0;
      end_err   <= 1'b0;
      rd_dat    <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= ack_take && !we;
      if (ack_take && !we) rd_dat <= wb_dat_i;

      if (cmd_fire) begin
        adr     <= cmd_adr_i & ~AW'(3);
        beats   <= (cmd_len_i == 5'd0) ? 5'd1 : cmd_len_i;
        burst   <= (cmd_len_i > 5'd1);
        we      <= cmd_we_i;
        bte     <= cmd_bte_i;
        rty_cnt <= '0;
        end_err <= 1'b0;
      end

      if (ack_take) begin
        adr     <= adr_inc;
        beats   <= beats - 5'd1;
        rty_cnt <= '0;
      end
      if (rty_take) rty_cnt <= rty_cnt + RW'(1);
      if (err_take || (rty_take && rty_abort)) end_err <= 1'b1;

      // A retried beat keeps its word; an aborted or finished command drops it.
      if (wr_fire) begin
        hold_dat  <= wr_dat_i;
        hold_full <= 1'b1;
      end else if (ack_take || state_nxt == ST_END) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: doc/wb_burst_master.md
Name: wb_burst_master

Overview:
Wishbone B3 initiator that turns simple block read/write commands into classic or registered-feedback burst cycles toward the interconnect or memory slave. It is the initiator-side counterpart of the burst-capable RAM slave. It serves as a boot/image loader, DMA front-end and bench traffic source. It sits on a master port of wb_intercon beside the CPU instruction and data buses.

Parameters:
- AW, 32, address width
- DW, 32, data width (word-addressed, sel all ones)
- RTY_MAX, 4, consecutive rty terminations tolerated per command before abort

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_we_i  in  1  1=write, 0=read
- cmd_adr_i  in  AW  start byte address; bits [1:0] ignored and forced to 0
- cmd_len_i  in  5  beat count, 1..16; 0 treated as 1
- cmd_bte_i  in  2  00 linear, 01 wrap4, 10 wrap8, 11 wrap16
- wr_dat_i  in  DW  write data stream
- wr_valid_i  in  1  write data valid
- wr_ready_o  out  1  write word consumed when valid&ready
- rd_dat_o  out  DW  read data
- rd_valid_o  out  1  read word strobe, no backpressure
- done_o  out  1  one-cycle pulse, command completed OK
- err_o  out  1  one-cycle pulse, command aborted
- wb_adr_o, wb_dat_o (DW), wb_sel_o (DW/8), wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o (3), wb_bte_o (2)  out  Wishbone master outputs
- wb_dat_i (DW), wb_ack_i, wb_err_i, wb_rty_i  in  Wishbone slave responses

Behaviour:
- Interface: one clock, wb_clk_i; wb_rst_i is asynchronous, active-high.
- Reset (async, including mid-burst): all outputs 0 immediately, FSM to IDLE, holding register empty, retry count 0. cyc drops with no termination and no done/err pulse.
- FSM states:
  - IDLE: cmd_ready_o=1. On accept, latch adr/len/we/bte and go to BUS.
  - BUS: cyc=1. stb=1 when read, or when write with the holding register full.
  - RETRY: cyc=0 for exactly 1 cycle, then back to BUS.
  - END: cyc=0 for 1 cycle, done_o or err_o pulses, then IDLE.
- Back-to-back commands: cmd_ready_o is 0 in all states except IDLE, so commands are always separated by at least one idle cycle.
- CTI/BTE: len==1 gives cti=000 (classic) and bte=00. Otherwise cti=010 on every beat except the last remaining beat, which is 111. bte=latched value throughout the command.
- Address: word-aligned. After each ack, the address advances by 4 within the wrap window:
  - linear: full increment
  - wrap4: adr[3:2] modulo
  - wrap8: adr[4:2] modulo
  - wrap16: adr[5:2] modulo
  - upper bits unchanged
- Beat counter decrements on ack. An ack on the last beat leads to END.
- Write holding register: wr_ready_o = write-active & BUS & (!hold_full | (wb_ack_i & stb & !last_beat)). This combinational path from ack allows zero-wait bursts. A missing wr_valid_i deasserts stb with cyc kept high (legal B3 wait) and cti unchanged.
- Read: rd_dat_o/rd_valid_o are registered, valid 1 cycle after ack. done_o coincides with the final rd_valid_o.
- Response priority: err > rty > ack. Responses while stb=0 are ignored.
  - err: go to END with err_o. Remaining beats are dropped. Unconsumed write words stay with the caller.
  - rty: retry count++, go to RETRY, then reissue the remaining beats from the current address with cti recomputed. If the count reaches RTY_MAX, go to END with err_o.
  - ack: clears the retry count.
- Wrap-around of the 32-bit address in linear mode is silent.

Decomposition:
- Shared package wb_pkg holds:
  - CTI_CLASSIC=3'b000, CTI_CONST=3'b001, CTI_INC=3'b010, CTI_EOB=3'b111
  - BTE_LINEAR/WRAP4/WRAP8/WRAP16
  - FSM state enum
- Sub-module wb_adr_next: combinational next-address computation from adr and bte. It is shared with the slave-side burst logic.

Test Plan:
1. Read, len=1, adr 0x104, ack after 2 waits -> cti=000, one rd_valid_o with data, done_o one cycle later with rd_valid_o.
2. Read, len=4, adr 0x100, linear, ack every cycle -> adr 0x100/104/108/10C, cti 010,010,010,111, 4 consecutive rd_valid_o, cyc high 4 cycles.
3. Write, len=4, wrap4, adr 0x10C, data A0..A3 -> adr 0x10C,0x100,0x104,0x108 with A0..A3, bte=01. A wr_valid_i gap after A1 lowers stb for 1 cycle with cyc held.
4. Read, len=8, err on beat 3 -> cyc low next cycle, err_o pulse, only 2 rd_valid_o, no done_o.
5. Write, len=2, rty on beat 1 twice then ack -> two RETRY gaps, beat 1 reissued at the same address/data, done_o. With RTY_MAX=2, the second rty gives err_o instead.
6. wb_rst_i asserted mid-way through a 16-beat burst -> cyc/stb/outputs 0 in the same cycle, no pulses, cmd_ready_o=1 after release.
